load_store_unit: RTL and testbench

// Memory-access stage directly downstream of the RISC_V execute stage. Takes the ALU result as the

---
 rtl/load_store_unit.sv | 85 ++++++++
 tb/tb_load_store_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV64 load/store stage with req/ack memory handshake and timeout
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
  state_t state, state_nx;
  logic [15:0] cnt;
  logic [2:0] f3, off;
  logic accept, illegal, misaligned, bad, tmo;
  logic [7:0] strb;
  logic [63:0] lane, ext;
  assign accept = req_valid && state == IDLE;
  assign illegal = req_we ? req_funct3[2] : &req_funct3;
  assign misaligned = req_funct3[1:0] == 2'd1 ? req_addr[0] :
                      req_funct3[1:0] == 2'd2 ? |req_addr[1:0] :
                      req_funct3[1:0] == 2'd3 ? |req_addr[2:0] : 1'b0;
  assign bad = illegal || misaligned;
  assign tmo = cnt == 16'(TIMEOUT - 1);
  assign strb = req_funct3[1:0] == 2'd0 ? 8'h01 :
                req_funct3[1:0] == 2'd1 ? 8'h03 :
                req_funct3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
  // Bring the addressed byte lane down to bit 0 before extending
  assign lane = mem_rdata >> {off, 3'b000};
  assign ext = f3 == 3'b000 ? {{56{lane[7]}}, lane[7:0]} :
               f3 == 3'b001 ? {{48{lane[15]}}, lane[15:0]} :
               f3 == 3'b010 ? {{32{lane[31]}}, lane[31:0]} :
               f3 == 3'b100 ? {56'd0, lane[7:0]} :
               f3 == 3'b101 ? {48'd0, lane[15:0]} :
               f3 == 3'b110 ? {32'd0, lane[31:0]} : lane;
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP || state == ERR;
  assign resp_err = state == ERR;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (accept ? (bad ? ERR : REQ) : IDLE) :
               state == REQ  ? (mem_ack ? RESP : tmo ? ERR : REQ) : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= 16'd0;
      f3 <= 3'd0;
      off <= 3'd0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= 64'd0;
      mem_wdata <= 64'd0;
      mem_wstrb <= 8'd0;
      resp_rdata <= 64'd0;
    end else begin
      cnt <= (state == REQ && !mem_ack && !tmo) ? cnt + 16'd1 : 16'd0;
      if (accept && !bad) begin
        mem_req <= 1'b1;
        mem_we <= req_we;
        mem_addr <= {req_addr[63:3], 3'b000};
        mem_wdata <= req_wdata << {req_addr[2:0], 3'b000};
        mem_wstrb <= req_we ? strb << req_addr[2:0] : 8'h00;
        f3 <= req_funct3;
        off <= req_addr[2:0];
      end else if (state == REQ && (mem_ack || tmo)) mem_req <= 1'b0;
      if (state == REQ && mem_ack) resp_rdata <= mem_we ? 64'd0 : ext;
      else if (state_nx == ERR) resp_rdata <= 64'd0;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: transaction-level timing model plus randomized and directed accesses
module tb_load_store_unit;
  localparam int T = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, mem_ack = 1'b0;
  logic [2:0] req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0, mem_rdata = 64'd0;
  logic req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [63:0] resp_rdata, mem_addr, mem_wdata;
  logic [7:0] mem_wstrb;

  load_store_unit #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  int cyc, nchk, nerr;
  bit chk_en;
  bit active, t_bad, t_we, t_err, got_acc;
  int acc, t_dly, t_end, resp_c, ready_at, pend_dly;
  logic [63:0] t_addr, t_wdata, t_exp, t_rd, pend_rd;
  logic [7:0] t_wstrb;
  int last_resp_cyc, mreq_cnt;
  logic [63:0] last_rdata, last_maddr, last_mwdata;
  logic last_err;
  logic [7:0] last_wstrb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_bad(input bit we, input logic [2:0] f3, input logic [63:0] a);
    int n;
    n = 1 << f3[1:0];
    return (we ? (f3 > 3'd3) : (f3 == 3'd7)) || (int'(a[2:0]) % n != 0);
  endfunction

  function automatic logic [63:0] load_val(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rd);
    int n;
    logic [63:0] v, m;
    n = 1 << f3[1:0];
    v = rd >> (8 * int'(a[2:0]));
    m = (n == 8) ? '1 : (64'd1 << (8 * n)) - 64'd1;
    v = v & m;
    if (!f3[2] && n < 8 && v[8 * n - 1]) v = v | ~m;
    return v;
  endfunction

  // Advance one cycle; record an acceptance of the previous cycle and drive memory for this one
  task automatic step();
    int n, off;
    bit in_win;
    @(posedge clk);
    #1;
    cyc++;
    if (req_valid && reset && cyc - 1 >= ready_at) begin
      active = 1; acc = cyc - 1; t_we = req_we; t_addr = req_addr;
      n = 1 << req_funct3[1:0]; off = int'(req_addr[2:0]);
      t_bad = is_bad(req_we, req_funct3, req_addr);
      t_dly = pend_dly; t_rd = pend_rd;
      t_wstrb = req_we ? 8'(((1 << n) - 1) << off) : 8'h00;
      t_wdata = req_wdata << (8 * off);
      if (t_bad) begin
        t_end = 0; resp_c = acc + 1; t_err = 1; t_exp = 64'd0;
      end else if (t_dly <= T) begin
        t_end = t_dly; resp_c = acc + t_dly + 1; t_err = 0;
        t_exp = req_we ? 64'd0 : load_val(req_funct3, req_addr, t_rd);
      end else begin
        t_end = T; resp_c = acc + T + 1; t_err = 1; t_exp = 64'd0;
      end
      ready_at = resp_c + 1; req_valid = 0; got_acc = 1; mreq_cnt = 0;
    end
    mem_rdata = {$urandom, $urandom};
    in_win = active && !t_bad && cyc >= acc + 1 && cyc <= acc + t_end;
    if (active && !t_bad && cyc == acc + t_dly) begin
      mem_ack = 1; mem_rdata = t_rd;
    end else mem_ack = !in_win && ($urandom % 4 == 0);
  endtask

  task automatic present(input bit we, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input int dly, input logic [63:0] rd);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    pend_dly = dly; pend_rd = rd; req_valid = 1; got_acc = 0;
  endtask

  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input int dly, input logic [63:0] rd);
    present(we, f3, a, wd, dly, rd);
    for (int i = 0; i < 40 && !(got_acc && cyc > resp_c); i++) step();
    if (!(got_acc && cyc > resp_c)) begin
      nchk++; nerr++;
      $display("FAIL txn_wait cyc=%0d actual=unfinished required=finished", cyc);
    end
  endtask

  task automatic present_rand();
    bit we;
    logic [2:0] f3;
    logic [63:0] a;
    we = 1'($urandom % 2);
    f3 = we ? 3'($urandom_range(0, 4)) : 3'($urandom % 8);
    a = {$urandom, $urandom};
    if ($urandom % 4 != 0) a = a & ~64'((1 << f3[1:0]) - 1);
    present(we, f3, a, {$urandom, $urandom}, $urandom_range(1, T + 2), {$urandom, $urandom});
  endtask

  always @(negedge clk) begin
    bit in_win, rv;
    if (chk_en) begin
      in_win = active && !t_bad && cyc >= acc + 1 && cyc <= acc + t_end;
      rv = active && cyc == resp_c;
      check("req_ready", 64'(req_ready), 64'(cyc >= ready_at));
      check("mem_req", 64'(mem_req), 64'(in_win));
      check("resp_valid", 64'(resp_valid), 64'(rv));
      if (rv) begin
        check("resp_err", 64'(resp_err), 64'(t_err));
        check("resp_rdata", resp_rdata, t_exp);
      end
      if (in_win) begin
        check("mem_addr", mem_addr, t_addr & ~64'd7);
        check("mem_we", 64'(mem_we), 64'(t_we));
        check("mem_wstrb", 64'(mem_wstrb), 64'(t_wstrb));
        if (t_we) check("mem_wdata", mem_wdata, t_wdata);
      end
      if (resp_valid) begin
        last_resp_cyc = cyc; last_rdata = resp_rdata; last_err = resp_err;
      end
      if (mem_req) begin
        mreq_cnt++; last_maddr = mem_addr; last_mwdata = mem_wdata; last_wstrb = mem_wstrb;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    int prev;
    #2 reset = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    reset = 1; cyc = 0; ready_at = 0; chk_en = 1;
    run_txn(1, 3'b011, 64'h1008, 64'h1122334455667788, 1, 64'd0);
    check("sd_latency", 64'(last_resp_cyc - acc), 64'd2);
    check("sd_mem_addr", last_maddr, 64'h1008);
    check("sd_wstrb", 64'(last_wstrb), 64'hFF);
    check("sd_err", 64'(last_err), 64'd0);
    run_txn(0, 3'b000, 64'h2007, 64'd0, 2, 64'h80FF_0000_0000_0000);
    check("lb_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    run_txn(0, 3'b100, 64'h2007, 64'd0, 1, 64'h80FF_0000_0000_0000);
    check("lbu_rdata", last_rdata, 64'h80);
    run_txn(0, 3'b001, 64'h2006, 64'd0, 3, 64'h80FF_0000_0000_0000);
    check("lh_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_80FF);
    run_txn(1, 3'b001, 64'h3003, 64'd0, 1, 64'd0);
    check("sh_mis_err", 64'(last_err), 64'd1);
    check("sh_mis_latency", 64'(last_resp_cyc - acc), 64'd1);
    check("sh_mis_no_mem", 64'(mreq_cnt), 64'd0);
    run_txn(0, 3'b111, 64'h3000, 64'd0, 1, 64'd0);
    check("ill_err", 64'(last_err), 64'd1);
    check("ill_no_mem", 64'(mreq_cnt), 64'd0);
    run_txn(0, 3'b011, 64'h5000, 64'd0, T + 2, 64'd0);
    check("tmo_err", 64'(last_err), 64'd1);
    check("tmo_latency", 64'(last_resp_cyc - acc), 64'(T + 1));
    check("tmo_req_cycles", 64'(mreq_cnt), 64'(T));
    run_txn(1, 3'b000, 64'h4005, 64'hAB, 4, 64'd0);
    check("sb_wstrb", 64'(last_wstrb), 64'h20);
    check("sb_wdata", last_mwdata, 64'h0000_AB00_0000_0000);
    check("sb_latency", 64'(last_resp_cyc - acc), 64'd5);
    prev = resp_c;
    run_txn(0, 3'b010, 64'h4004, 64'd0, 1, 64'hDEAD_BEEF_8000_0001);
    check("b2b_accept", 64'(acc), 64'(prev + 1));
    check("lw_rdata", last_rdata, 64'hFFFF_FFFF_DEAD_BEEF);
    present(0, 3'b011, 64'h5000, 64'd0, T + 2, 64'd0);
    for (int i = 0; i < 10 && !(got_acc && cyc >= acc + 2); i++) step();
    chk_en = 0;
    check("pre_rst_mem_req", 64'(mem_req), 64'd1);
    reset = 0;
    #1;
    check("mid_rst_mem_req", 64'(mem_req), 64'd0);
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    active = 0; req_valid = 0;
    repeat (2) step();
    reset = 1; ready_at = cyc; chk_en = 1;
    run_txn(0, 3'b011, 64'h5008, 64'd0, 2, 64'h0123_4567_89AB_CDEF);
    check("post_rst_rdata", last_rdata, 64'h0123_4567_89AB_CDEF);
    check("post_rst_err", 64'(last_err), 64'd0);
    for (int i = 0; i < 4000; i++) begin
      if (!req_valid && $urandom_range(0, 2) != 0) present_rand();
      step();
    end
    for (int i = 0; i < 60 && (req_valid || cyc <= resp_c); i++) step();
    if (req_valid || cyc <= resp_c) begin
      nchk++; nerr++;
      $display("FAIL drain cyc=%0d actual=busy required=idle", cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
